// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU first, DMA after MAX_WAIT denials.
// Ports: cpu_*/dma_* request/response, mem_* to memory, dma_starved status.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_valid,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dma_starved
);

  localparam logic [3:0]  MAX_W   = 4'(MAX_WAIT);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    owner_t      owner;
    logic        err;
  } cmd_t;

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [3:0] wait_q, wait_d;
  logic       starved;
  logic       cpu_acc, dma_acc;
  logic       busy, mem_go;
  logic [31:0] rsp_data;

  function automatic logic out_of_range(input logic [31:0] a);
    return a[31:2] >= DEPTH_W;
  endfunction

  assign starved     = (wait_q == MAX_W);
  assign dma_starved = starved;

  // Grant: disjoint cases so exactly one arm can match.
  always_comb begin
    cpu_ready = 1'b0;
    dma_ready = 1'b0;
    unique case (1'b1)
      (cpu_valid & dma_valid): begin
        if (starved) dma_ready = 1'b1;
        else         cpu_ready = 1'b1;
      end
      (cpu_valid & !dma_valid): cpu_ready = 1'b1;
      (!cpu_valid & dma_valid): dma_ready = 1'b1;
      default: ;
    endcase
  end

  assign cpu_acc = cpu_valid & cpu_ready;
  assign dma_acc = dma_valid & dma_ready;

  always_comb begin
    wait_d = wait_q;
    unique case (1'b1)
      dma_acc:                             wait_d = '0;
      (dma_valid & !dma_ready & !starved): wait_d = wait_q + 4'd1;
      default: ;
    endcase
  end

  // Command latch: an access cycle follows every acceptance,
  // so back-to-back acceptance keeps the state in S_ACCESS.
  always_comb begin
    cmd_d   = cmd_q;
    state_d = S_IDLE;
    unique case (1'b1)
      cpu_acc: begin
        cmd_d.addr  = cpu_addr;
        cmd_d.wdata = cpu_wdata;
        cmd_d.we    = cpu_we;
        cmd_d.owner = OWN_CPU;
        cmd_d.err   = out_of_range(cpu_addr);
        state_d     = S_ACCESS;
      end
      dma_acc: begin
        cmd_d.addr  = dma_addr;
        cmd_d.wdata = dma_wdata;
        cmd_d.we    = dma_we;
        cmd_d.owner = OWN_DMA;
        cmd_d.err   = out_of_range(dma_addr);
        state_d     = S_ACCESS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      wait_q  <= wait_d;
    end
  end

  assign busy   = (state_q == S_ACCESS);
  assign mem_go = busy & !cmd_q.err;

  // Out-of-range commands never drive the memory.
  assign mem_read  = mem_go & !cmd_q.we;
  assign mem_write = mem_go & cmd_q.we;
  assign mem_addr  = mem_go ? cmd_q.addr : '0;
  assign mem_wdata = mem_go ? cmd_q.wdata : '0;

  assign rsp_data = mem_read ? mem_rdata : '0;

  // Response: only the owner's side updates; the other holds rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
    end else begin
      cpu_rvalid <= busy & (cmd_q.owner == OWN_CPU);
      dma_rvalid <= busy & (cmd_q.owner == OWN_DMA);
      if (busy & (cmd_q.owner == OWN_CPU)) begin
        cpu_rdata <= rsp_data;
        cpu_err   <= cmd_q.err;
      end
      if (busy & (cmd_q.owner == OWN_DMA)) begin
        dma_rdata <= rsp_data;
        dma_err   <= cmd_q.err;
      end
    end
  end

endmodule
